// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants, fetch FSM encoding and FIFO entry layout for the
// instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic                   RstEnable      = 1'b1;
    localparam logic [InstBus-1:0]     ZeroWord       = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'b00,
        FETCH_WAIT  = 2'b01,
        FETCH_DRAIN = 2'b10
    } fetchState_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetchEntry_t;

    function automatic logic [InstAddrBus-1:0] alignPc(input logic [InstAddrBus-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; clear empties it
// in one edge and takes priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A push at full is only legal when the head leaves in the same cycle.
    assign doPush = push_i && (!full_o || pop_i);
    assign doPop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the single-outstanding imem
// handshake and buffers {pc, inst} pairs for the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC  = DefaultResetPc,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] flush_pc_i,
    output logic                   inst_valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    fetchState_e                state_q, state_d;
    logic [InstAddrBus-1:0]     fetchPc_q, fetchPc_d;
    logic [InstAddrBus-1:0]     redirectPc_q, redirectPc_d;
    logic                       req;
    logic                       popReq;
    logic                       doPush;
    logic                       doPop;
    logic                       fifoFull;
    logic                       fifoEmpty;
    logic [$clog2(BUF_DEPTH):0] fifoCount;
    logic                       unusedCount;
    fetchEntry_t                pushEntry;
    fetchEntry_t                headEntry;

    assign popReq      = !fifoEmpty && !stall_i;
    assign doPop       = popReq && !flush_i;
    assign pushEntry   = '{pc: fetchPc_q, inst: imem_rdata_i};
    assign unusedCount = ^fifoCount;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= FETCH_ISSUE;
            fetchPc_q    <= RESET_PC;
            redirectPc_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetchPc_q    <= fetchPc_d;
            redirectPc_q <= redirectPc_d;
        end
    end

    // A flush while a request is still unacknowledged must let it finish, so
    // the redirect is parked and the returning word is thrown away in DRAIN.
    always_comb begin
        state_d      = state_q;
        fetchPc_d    = fetchPc_q;
        redirectPc_d = redirectPc_q;
        doPush       = 1'b0;
        if (flush_i) begin
            if (req && !imem_ack_i) begin
                redirectPc_d = alignPc(flush_pc_i);
                state_d      = FETCH_DRAIN;
            end else begin
                fetchPc_d = alignPc(flush_pc_i);
                state_d   = FETCH_ISSUE;
            end
        end else begin
            case (state_q)
                FETCH_ISSUE: begin
                    if (req && imem_ack_i) begin
                        doPush    = 1'b1;
                        fetchPc_d = fetchPc_q + 32'd4;
                    end else if (req) begin
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_ack_i) begin
                        doPush    = 1'b1;
                        fetchPc_d = fetchPc_q + 32'd4;
                        state_d   = FETCH_ISSUE;
                    end
                end
                FETCH_DRAIN: begin
                    if (imem_ack_i) begin
                        fetchPc_d = redirectPc_q;
                        state_d   = FETCH_ISSUE;
                    end
                end
                default: state_d = FETCH_ISSUE;
            endcase
        end
    end

    // ISSUE only asks for a word when a slot will be free after this cycle's pop.
    always_comb begin
        req = 1'b0;
        case (state_q)
            FETCH_ISSUE: req = !fifoFull || popReq;
            FETCH_WAIT:  req = 1'b1;
            FETCH_DRAIN: req = 1'b1;
            default:     req = 1'b0;
        endcase
        if (rst == RstEnable) begin
            req = 1'b0;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = fetchPc_q;
    assign inst_valid_o = !fifoEmpty;
    assign pc_o         = fifoEmpty ? ZeroWord : headEntry.pc;
    assign inst_o       = fifoEmpty ? ZeroWord : headEntry.inst;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetchEntry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .push_i  (doPush),
        .pop_i   (doPop),
        .data_i  (pushEntry),
        .data_o  (headEntry),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run, checked
// against a stream-level model of which PCs must come out and in what order.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic [31:0] rdata2;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expPc;
    bit          prevPending;
    logic [31:0] prevAddr;
    int          waitCnt;
    int          lat;
    bit          randLat;
    int          ackCount;
    int          popCount;
    bit          seen;
    logic [31:0] wrapPc;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    // Second instance starts near the top of the address space with an
    // always-ready memory, to exercise the reset PC and the 32-bit wrap.
    assign rdata2 = memWord(addr2);

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (req2),
        .imem_addr_o  (addr2),
        .imem_ack_i   (req2),
        .imem_rdata_i (rdata2),
        .stall_i      (1'b0),
        .flush_i      (1'b0),
        .flush_pc_i   (32'h0),
        .inst_valid_o (valid2),
        .pc_o         (pc2),
        .inst_o       (inst2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic doReset(input int fixedLat, input bit useRandLat);
        @(negedge clk);
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; imem_ack_i = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_req", imem_req_o, 1'b0);
        checkOutput("rst_addr", imem_addr_o, 32'h0);
        checkOutput("rst_valid", inst_valid_o, 1'b0);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_inst", inst_o, 32'h0);
        checkOutput("rst_addr2", addr2, 32'hFFFF_FFF8);
        expPc = 32'h0; prevPending = 1'b0; prevAddr = 32'h0; waitCnt = 0;
        randLat = useRandLat;
        lat = useRandLat ? int'($urandom_range(0, 3)) : fixedLat;
        ackCount = 0; popCount = 0;
    endtask

    // One cycle: drive inputs, let memory answer, then check the head against
    // the expected instruction stream and the request against the handshake rules.
    task automatic applyStimulus(input bit stall, input bit flush, input logic [31:0] fpc);
        @(negedge clk);
        rst = 1'b0; stall_i = stall; flush_i = flush; flush_pc_i = fpc;
        #1;
        if (imem_req_o) begin
            if (waitCnt >= lat) begin
                imem_ack_i = 1'b1; imem_rdata_i = memWord(imem_addr_o);
                waitCnt = 0; ackCount++;
                if (randLat) lat = $urandom_range(0, 3);
            end else begin
                imem_ack_i = 1'b0; imem_rdata_i = $urandom; waitCnt++;
            end
        end else begin
            imem_ack_i = 1'b0; imem_rdata_i = $urandom;
        end
        #1;
        checkOutput("addr_align", {30'b0, imem_addr_o[1:0]}, 32'h0);
        if (prevPending) begin
            checkOutput("req_held", imem_req_o, 1'b1);
            checkOutput("addr_stable", imem_addr_o, prevAddr);
        end
        if (inst_valid_o) begin
            checkOutput("head_pc", pc_o, expPc);
            checkOutput("head_inst", inst_o, memWord(expPc));
            if (!stall && !flush) begin
                expPc = expPc + 32'd4; popCount++;
            end
        end else begin
            checkOutput("empty_pc", pc_o, 32'h0);
            checkOutput("empty_inst", inst_o, 32'h0);
        end
        if (flush) expPc = fpc & ~32'h3;
        prevPending = imem_req_o && !imem_ack_i;
        prevAddr = imem_addr_o;
    endtask

    initial begin
        $display("[TB] zero-wait streaming and RESET_PC wrap");
        doReset(0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("t1_req", imem_req_o, 1'b1);
            checkOutput("t1_addr", imem_addr_o, 32'(4 * i));
            checkOutput("t1_valid", inst_valid_o, (i > 0));
            if (i > 0) checkOutput("t1_pc", pc_o, 32'(4 * (i - 1)));
            if (i >= 1 && i <= 3) begin
                wrapPc = 32'hFFFF_FFF8 + 32'(4 * (i - 1));
                checkOutput("t1_wrap_valid", valid2, 1'b1);
                checkOutput("t1_wrap_pc", pc2, wrapPc);
                checkOutput("t1_wrap_inst", inst2, memWord(wrapPc));
            end
        end

        $display("[TB] three-cycle memory latency");
        doReset(2, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t2_acks", ackCount, 4);
        checkOutput("t2_pops", popCount, 3);

        $display("[TB] downstream stall fills the buffer");
        doReset(0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_req_off", imem_req_o, 1'b0);
        checkOutput("t3_valid", inst_valid_o, 1'b1);
        checkOutput("t3_pc_held", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("t3_release_pc", pc_o, 32'(4 * i));
        end

        $display("[TB] flush while a request is waiting");
        doReset(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_req", imem_req_o, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_1003);
        checkOutput("t4_flush_empty", inst_valid_o, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("t4_old_addr", imem_addr_o, 32'h0);
            checkOutput("t4_still_empty", inst_valid_o, 1'b0);
            seen = imem_ack_i;
        end
        checkOutput("t4_ack_seen", seen, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_new_req", imem_req_o, 1'b1);
        checkOutput("t4_new_addr", imem_addr_o, 32'h0000_1000);
        checkOutput("t4_dropped", inst_valid_o, 1'b0);

        $display("[TB] flush with pop and push at full");
        doReset(0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_2000);
        checkOutput("t5_req", imem_req_o, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t5_empty", inst_valid_o, 1'b0);
        checkOutput("t5_addr", imem_addr_o, 32'h0000_2000);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t5_valid", inst_valid_o, 1'b1);
        checkOutput("t5_pc", pc_o, 32'h0000_2000);

        $display("[TB] randomized latency, stall and flush");
        doReset(0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 19) == 0,
                          ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
        end
        checkOutput("t6_progress", (popCount > 50), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
